// File: rtl/result_broadcaster.sv
// Result-bus transmit side: per-FU completion FIFOs, round-robin arbitration with
// an instruction-granular lock, and one-PRN-per-cycle broadcast plus completion pulse.
module result_broadcaster #(
  parameter int NUM_FUS      = 4,
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fu_valid     [NUM_FUS],
  output logic                    fu_ready     [NUM_FUS],
  input  logic [INST_ID_BITS-1:0] fu_inst_id   [NUM_FUS],
  input  logic                    fu_out_en    [NUM_FUS][MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     fu_out_prn   [NUM_FUS][MAX_OPERANDS],
  input  logic [DATA_W-1:0]       fu_out_value [NUM_FUS][MAX_OPERANDS],
  output logic                    result_valid,
  output logic [PRN_BITS-1:0]     result_prn,
  output logic [DATA_W-1:0]       result_value,
  output logic                    complete_valid,
  output logic [INST_ID_BITS-1:0] complete_inst_id
);

  localparam int FU_W  = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SL_W  = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;

  logic [INST_ID_BITS-1:0] id_mem   [NUM_FUS][FIFO_DEPTH];
  logic [PRN_BITS-1:0]     prn_mem  [NUM_FUS][FIFO_DEPTH][MAX_OPERANDS];
  logic [DATA_W-1:0]       val_mem  [NUM_FUS][FIFO_DEPTH][MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0] mask_q   [NUM_FUS][FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q [NUM_FUS];
  logic [PTR_W-1:0]        rd_ptr_q [NUM_FUS];
  logic [CNT_W-1:0]        count_q  [NUM_FUS];
  logic                    lock_q;
  logic [FU_W-1:0]         lock_fu_q;
  logic [FU_W-1:0]         rr_q;

  logic                    push     [NUM_FUS];
  logic [MAX_OPERANDS-1:0] en_mask  [NUM_FUS];
  logic                    sel_valid;
  logic [FU_W-1:0]         sel_fu;
  logic [FU_W-1:0]         rr_next;
  logic [PTR_W-1:0]        head_ptr;
  logic [MAX_OPERANDS-1:0] head_mask;
  logic [MAX_OPERANDS-1:0] rest_mask;
  logic [SL_W-1:0]         slot;
  logic                    head_has_slot;
  logic                    pop;

  logic                    vld_p0;
  logic [PRN_BITS-1:0]     prn_p0;
  logic [DATA_W-1:0]       value_p0;
  logic                    cmp_vld_p0;
  logic [INST_ID_BITS-1:0] cmp_id_p0;

  always_comb begin
    for (int i = 0; i < NUM_FUS; i++) begin
      fu_ready[i] = !rst && (count_q[i] < CNT_W'(FIFO_DEPTH));
      push[i]     = fu_valid[i] && fu_ready[i];
      en_mask[i]  = '0;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        en_mask[i][k] = fu_out_en[i][k];
      end
    end
  end

  // Lock keeps a multi-result instruction on the bus; otherwise search from rr with wrap.
  always_comb begin
    sel_valid = 1'b0;
    sel_fu    = '0;
    if (lock_q) begin
      sel_valid = 1'b1;
      sel_fu    = lock_fu_q;
    end else begin
      for (int off = 0; off < NUM_FUS; off++) begin
        if (!sel_valid && count_q[(int'(rr_q) + off) % NUM_FUS] != '0) begin
          sel_valid = 1'b1;
          sel_fu    = FU_W'((int'(rr_q) + off) % NUM_FUS);
        end
      end
    end
  end

  always_comb begin
    head_ptr      = rd_ptr_q[sel_fu];
    head_mask     = mask_q[sel_fu][head_ptr];
    slot          = '0;
    head_has_slot = |head_mask;
    for (int k = MAX_OPERANDS - 1; k >= 0; k--) begin
      if (head_mask[k]) slot = SL_W'(k);
    end
    rest_mask = head_mask;
    if (head_has_slot) rest_mask[slot] = 1'b0;
    pop     = sel_valid && (rest_mask == '0);
    rr_next = (sel_fu == FU_W'(NUM_FUS - 1)) ? '0 : sel_fu + 1'b1;
  end

  // Payload storage carries no reset; occupancy is tracked by the control state.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FUS; i++) begin
      if (push[i]) begin
        id_mem[i][wr_ptr_q[i]] <= fu_inst_id[i];
        for (int k = 0; k < MAX_OPERANDS; k++) begin
          prn_mem[i][wr_ptr_q[i]][k] <= fu_out_prn[i][k];
          val_mem[i][wr_ptr_q[i]][k] <= fu_out_value[i][k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FUS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        for (int d = 0; d < FIFO_DEPTH; d++) mask_q[i][d] <= '0;
      end
      lock_q    <= 1'b0;
      lock_fu_q <= '0;
      rr_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_FUS; i++) begin
        if (push[i]) begin
          wr_ptr_q[i]              <= wr_ptr_q[i] + 1'b1;
          mask_q[i][wr_ptr_q[i]]   <= en_mask[i];
        end
        count_q[i] <= count_q[i] + CNT_W'(push[i])
                    - CNT_W'(pop && (sel_fu == FU_W'(i)));
      end
      if (sel_valid) begin
        mask_q[sel_fu][head_ptr] <= rest_mask;
        if (pop) begin
          rd_ptr_q[sel_fu] <= head_ptr + 1'b1;
          lock_q           <= 1'b0;
          rr_q             <= rr_next;
        end else begin
          lock_q    <= 1'b1;
          lock_fu_q <= sel_fu;
        end
      end
    end
  end

  // Stage p0: registered broadcast and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      prn_p0     <= '0;
      value_p0   <= '0;
      cmp_vld_p0 <= 1'b0;
      cmp_id_p0  <= '0;
    end else begin
      vld_p0     <= sel_valid && head_has_slot;
      prn_p0     <= (sel_valid && head_has_slot) ? prn_mem[sel_fu][head_ptr][slot] : '0;
      value_p0   <= (sel_valid && head_has_slot) ? val_mem[sel_fu][head_ptr][slot] : '0;
      cmp_vld_p0 <= pop;
      cmp_id_p0  <= pop ? id_mem[sel_fu][head_ptr] : '0;
    end
  end

  assign result_valid     = vld_p0;
  assign result_prn       = prn_p0;
  assign result_value     = value_p0;
  assign complete_valid   = cmp_vld_p0;
  assign complete_inst_id = cmp_id_p0;

endmodule

// File: tb/tb_result_broadcaster.sv
// Directed bench for result_broadcaster: reset, single/multi-slot broadcast, lock,
// round-robin order, FIFO full with wrap, zero-mask completion and mid-broadcast reset.
module tb_result_broadcaster;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fu_valid     [4];
  logic        fu_ready     [4];
  logic [5:0]  fu_inst_id   [4];
  logic        fu_out_en    [4][3];
  logic [5:0]  fu_out_prn   [4][3];
  logic [63:0] fu_out_value [4][3];
  logic        result_valid;
  logic [5:0]  result_prn;
  logic [63:0] result_value;
  logic        complete_valid;
  logic [5:0]  complete_inst_id;

  int checks = 0;
  int failures = 0;

  result_broadcaster dut (
    .clk(clk), .rst(rst),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_inst_id(fu_inst_id),
    .fu_out_en(fu_out_en), .fu_out_prn(fu_out_prn), .fu_out_value(fu_out_value),
    .result_valid(result_valid), .result_prn(result_prn), .result_value(result_value),
    .complete_valid(complete_valid), .complete_inst_id(complete_inst_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int i = 0; i < 4; i++) begin
      fu_valid[i]   = 1'b0;
      fu_inst_id[i] = '0;
      for (int k = 0; k < 3; k++) begin
        fu_out_en[i][k]    = 1'b0;
        fu_out_prn[i][k]   = '0;
        fu_out_value[i][k] = '0;
      end
    end
  endtask

  task automatic set_entry(input int fu, input int id, input logic [2:0] en,
                           input int p0, input int p1, input int p2,
                           input logic [63:0] v0, input logic [63:0] v1, input logic [63:0] v2);
    fu_valid[fu]        = 1'b1;
    fu_inst_id[fu]      = 6'(id);
    fu_out_en[fu][0]    = en[0];
    fu_out_en[fu][1]    = en[1];
    fu_out_en[fu][2]    = en[2];
    fu_out_prn[fu][0]   = 6'(p0);
    fu_out_prn[fu][1]   = 6'(p1);
    fu_out_prn[fu][2]   = 6'(p2);
    fu_out_value[fu][0] = v0;
    fu_out_value[fu][1] = v1;
    fu_out_value[fu][2] = v2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fu_ready[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready[%0d] got=%b want=0", i, fu_ready[i]);
      end
    end
    checks++;
    if ({result_valid, result_prn, result_value, complete_valid, complete_inst_id} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rv=%b prn=%0d val=%h cv=%b id=%0d want all 0",
               result_valid, result_prn, result_value, complete_valid, complete_inst_id);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fu_ready[i] !== 1'b1) begin
        failures++;
        $display("FAIL post_reset_ready[%0d] got=%b want=1", i, fu_ready[i]);
      end
    end
  endtask

  task automatic test_single();
    clear_in();
    set_entry(0, 5, 3'b001, 12, 0, 0, 64'hDEAD, 0, 0);
    tick();
    clear_in();
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_latency rv got=%b want=0", result_valid);
    end
    tick();
    checks++;
    if (result_valid !== 1'b1 || result_prn !== 6'd12 || result_value !== 64'hDEAD) begin
      failures++;
      $display("FAIL single_bcast got rv=%b prn=%0d val=%h want 1/12/dead",
               result_valid, result_prn, result_value);
    end
    checks++;
    if (complete_valid !== 1'b1 || complete_inst_id !== 6'd5) begin
      failures++;
      $display("FAIL single_complete got cv=%b id=%0d want 1/5", complete_valid, complete_inst_id);
    end
    tick();
    checks++;
    if ({result_valid, result_prn, result_value, complete_valid, complete_inst_id} !== '0) begin
      failures++;
      $display("FAIL single_idle got rv=%b prn=%0d cv=%b id=%0d want all 0",
               result_valid, result_prn, complete_valid, complete_inst_id);
    end
  endtask

  task automatic test_two_slot();
    clear_in();
    set_entry(1, 9, 3'b101, 3, 0, 7, 64'h11, 0, 64'h22);
    tick();
    clear_in();
    set_entry(2, 4, 3'b001, 20, 0, 0, 64'h33, 0, 0);
    tick();
    clear_in();
    checks++;
    if (result_valid !== 1'b1 || result_prn !== 6'd3 || result_value !== 64'h11 || complete_valid !== 1'b0) begin
      failures++;
      $display("FAIL two_slot_first got rv=%b prn=%0d val=%h cv=%b want 1/3/11/0",
               result_valid, result_prn, result_value, complete_valid);
    end
    tick();
    checks++;
    if (result_valid !== 1'b1 || result_prn !== 6'd7 || result_value !== 64'h22) begin
      failures++;
      $display("FAIL two_slot_second got rv=%b prn=%0d val=%h want 1/7/22",
               result_valid, result_prn, result_value);
    end
    checks++;
    if (complete_valid !== 1'b1 || complete_inst_id !== 6'd9) begin
      failures++;
      $display("FAIL two_slot_complete got cv=%b id=%0d want 1/9", complete_valid, complete_inst_id);
    end
    tick();
    checks++;
    if (result_prn !== 6'd20 || result_value !== 64'h33 || complete_inst_id !== 6'd4) begin
      failures++;
      $display("FAIL two_slot_fu2_after got prn=%0d val=%h id=%0d want 20/33/4",
               result_prn, result_value, complete_inst_id);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || complete_valid !== 1'b0) begin
      failures++;
      $display("FAIL two_slot_idle got rv=%b cv=%b want 0/0", result_valid, complete_valid);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    clear_in();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_entry(i, 10 + i, 3'b001, 40 + i, 0, 0, 64'(256 + i), 0, 0);
    tick();
    clear_in();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (result_valid !== 1'b1 || result_prn !== 6'(40 + k) || result_value !== 64'(256 + k)) begin
        failures++;
        $display("FAIL rr_order[%0d] got rv=%b prn=%0d val=%h want 1/%0d/%h",
                 k, result_valid, result_prn, result_value, 40 + k, 256 + k);
      end
      checks++;
      if (complete_valid !== 1'b1 || complete_inst_id !== 6'(10 + k)) begin
        failures++;
        $display("FAIL rr_complete[%0d] got cv=%b id=%0d want 1/%0d", k, complete_valid, complete_inst_id, 10 + k);
      end
    end
    tick();
    set_entry(1, 11, 3'b001, 51, 0, 0, 64'h51, 0, 0);
    set_entry(3, 13, 3'b001, 53, 0, 0, 64'h53, 0, 0);
    tick();
    clear_in();
    tick();
    checks++;
    if (result_valid !== 1'b1 || result_prn !== 6'd51) begin
      failures++;
      $display("FAIL rr_pair_first got rv=%b prn=%0d want 1/51", result_valid, result_prn);
    end
    tick();
    checks++;
    if (result_valid !== 1'b1 || result_prn !== 6'd53) begin
      failures++;
      $display("FAIL rr_pair_second got rv=%b prn=%0d want 1/53", result_valid, result_prn);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    logic        exp_rdy [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        exp_rv  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int          exp_prn [10] = '{0, 1, 2, 3, 61, 62, 63, 64, 65, 0};
    logic [63:0] exp_val [10] = '{64'h0, 64'hA1, 64'hA2, 64'hA3, 64'h601, 64'h602, 64'h603, 64'h604, 64'h605, 64'h0};
    logic        exp_cv  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int          exp_id  [10] = '{0, 0, 0, 30, 21, 22, 23, 24, 25, 0};
    int          n;
    // Move the rr pointer to FU1 so the FU1 instruction is granted first.
    clear_in();
    set_entry(0, 19, 3'b001, 59, 0, 0, 64'h59, 0, 0);
    tick();
    clear_in();
    tick();
    checks++;
    if (result_valid !== 1'b1 || result_prn !== 6'd59) begin
      failures++;
      $display("FAIL full_pre got rv=%b prn=%0d want 1/59", result_valid, result_prn);
    end
    for (int k = 0; k < 10; k++) begin
      clear_in();
      n = (k <= 3) ? k + 1 : ((k <= 5) ? 5 : 0);
      if (n != 0) set_entry(0, 20 + n, 3'b001, 60 + n, 0, 0, 64'(1536 + n), 0, 0);
      if (k == 0) set_entry(1, 30, 3'b111, 1, 2, 3, 64'hA1, 64'hA2, 64'hA3);
      tick();
      checks++;
      if (fu_ready[0] !== exp_rdy[k]) begin
        failures++;
        $display("FAIL full_ready[%0d] got=%b want=%b", k, fu_ready[0], exp_rdy[k]);
      end
      checks++;
      if (result_valid !== exp_rv[k] || result_prn !== 6'(exp_prn[k]) || result_value !== exp_val[k]) begin
        failures++;
        $display("FAIL full_bcast[%0d] got rv=%b prn=%0d val=%h want %b/%0d/%h",
                 k, result_valid, result_prn, result_value, exp_rv[k], exp_prn[k], exp_val[k]);
      end
      checks++;
      if (complete_valid !== exp_cv[k] || complete_inst_id !== 6'(exp_id[k])) begin
        failures++;
        $display("FAIL full_complete[%0d] got cv=%b id=%0d want %b/%0d",
                 k, complete_valid, complete_inst_id, exp_cv[k], exp_id[k]);
      end
    end
  endtask

  task automatic test_zero_mask_reset();
    clear_in();
    set_entry(2, 2, 3'b000, 0, 0, 0, 0, 0, 0);
    set_entry(3, 33, 3'b111, 4, 5, 6, 64'hB4, 64'hB5, 64'hB6);
    tick();
    clear_in();
    tick();
    checks++;
    if (result_valid !== 1'b0 || complete_valid !== 1'b1 || complete_inst_id !== 6'd2) begin
      failures++;
      $display("FAIL zero_mask got rv=%b cv=%b id=%0d want 0/1/2", result_valid, complete_valid, complete_inst_id);
    end
    tick();
    checks++;
    if (result_valid !== 1'b1 || result_prn !== 6'd4 || complete_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_first got rv=%b prn=%0d cv=%b want 1/4/0", result_valid, result_prn, complete_valid);
    end
    tick();
    checks++;
    if (result_valid !== 1'b1 || result_prn !== 6'd5) begin
      failures++;
      $display("FAIL mid_second got rv=%b prn=%0d want 1/5", result_valid, result_prn);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fu_ready[3] !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_ready got=%b want=0", fu_ready[3]);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || result_prn !== 6'd0 || complete_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_out got rv=%b prn=%0d cv=%b want 0/0/0", result_valid, result_prn, complete_valid);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (result_valid !== 1'b0 || complete_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_rst_quiet[%0d] got rv=%b prn=%0d cv=%b want 0/-/0",
                 k, result_valid, result_prn, complete_valid);
      end
    end
    checks++;
    if (fu_ready[3] !== 1'b1) begin
      failures++;
      $display("FAIL post_rst_ready got=%b want=1", fu_ready[3]);
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_single();
    test_two_slot();
    test_round_robin();
    test_fifo_full();
    test_zero_mask_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
